ahb_slave_interface: RTL and testbench

AHB-side front end of the AHB2APB bridge, directly downstream of the AHB master.
- Qualifies AHB transfers and decodes the target APB slave.
- Pipelines address, write data and direction for the APB controller FSM.
- Returns ready, response and read data to the master, and generates the two-cycle ERROR response for unmapped addresses.

---
 rtl/ahb_slave_interface_pkg.sv | 32 +++
 rtl/ahb_slave_interface_if.sv | 37 +++
 rtl/ahb_slave_interface_addr_decode.sv | 41 ++++
 rtl/ahb_slave_interface.sv | 128 ++++++++++++
 tb/tb_ahb_slave_interface.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_slave_interface_pkg.sv
// Shared AHB/APB bridge definitions: transfer and response encodings,
// default address map and the ERROR-response state encoding.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam logic [31:0] MAP_BASE_DEF   = 32'h8000_0000;
    localparam logic [31:0] SLAVE_SPAN_DEF = 32'h0400_0000;
    localparam int          NUM_SLAVES     = 3;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'b00,
        ERR_1    = 2'b01,
        ERR_2    = 2'b10
    } err_state_e;

    // NONSEQ and SEQ both carry bit 1 set; IDLE and BUSY never do.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_slave_interface_if.sv
// AHB slave-side bus bundle between the master, the bridge front end and the APB controller.
interface ahb_slave_interface_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              Hwrite;
    logic              Hreadyin;
    logic [1:0]        Htrans;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Prdata;
    logic              apb_ready;

    logic              valid;
    logic [2:0]        tempselx;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata1;
    logic [DATA_W-1:0] Hwdata2;
    logic              Hwritereg;
    logic              Hwritereg1;
    logic              Hreadyout;
    logic [1:0]        Hresp;
    logic [DATA_W-1:0] Hrdata;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, apb_ready,
        output valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
               Hwritereg, Hwritereg1, Hreadyout, Hresp, Hrdata
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, apb_ready,
        input  valid, tempselx, Haddr1, Haddr2, Hwdata1, Hwdata2,
               Hwritereg, Hwritereg1, Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_slave_interface_addr_decode.sv
// Combinational Haddr -> one-hot APB slave select. Optional macro
// AHB_SLV_ALIGN_CHECK_EN makes word-misaligned addresses decode as unmapped.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] MAP_BASE   = MAP_BASE_DEF,
    parameter logic [31:0] SLAVE_SPAN = SLAVE_SPAN_DEF
) (
    input  logic [ADDR_W-1:0] i_haddr,
    output logic [2:0]        o_tempselx,
    output logic              o_mapped
);
    // Two guard bits keep the window limits from wrapping past the top of the address space.
    localparam int XW = ADDR_W + 2;
    localparam logic [XW-1:0] LIM0 = XW'(MAP_BASE);
    localparam logic [XW-1:0] LIM1 = LIM0 + XW'(SLAVE_SPAN);
    localparam logic [XW-1:0] LIM2 = LIM1 + XW'(SLAVE_SPAN);
    localparam logic [XW-1:0] LIM3 = LIM2 + XW'(SLAVE_SPAN);

    logic [XW-1:0] w_addr_x;
    logic          w_in0;
    logic          w_in1;
    logic          w_in2;
    logic          w_aligned;

    assign w_addr_x = {2'b00, i_haddr};
    assign w_in0    = (w_addr_x >= LIM0) && (w_addr_x < LIM1);
    assign w_in1    = (w_addr_x >= LIM1) && (w_addr_x < LIM2);
    assign w_in2    = (w_addr_x >= LIM2) && (w_addr_x < LIM3);

`ifdef AHB_SLV_ALIGN_CHECK_EN
    assign w_aligned = (i_haddr[1:0] == 2'b00);
`else
    assign w_aligned = 1'b1;
`endif

    assign o_tempselx = w_aligned ? {w_in2, w_in1, w_in0} : 3'b000;
    assign o_mapped   = |o_tempselx;

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB front end of the AHB2APB bridge: decode, address/data pipeline and
// two-cycle ERROR generation. Optional macro: AHB_SLV_ALIGN_CHECK_EN.
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] MAP_BASE   = MAP_BASE_DEF,
    parameter logic [31:0] SLAVE_SPAN = SLAVE_SPAN_DEF
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    ahb_slave_interface_if.slave  bus
);
    logic [2:0]        w_tempselx;
    logic              w_mapped;
    logic              w_active;
    logic              w_err_req;
    logic              w_hreadyout;
    logic [1:0]        w_hresp;
    err_state_e        r_state;
    err_state_e        w_next;

    logic [ADDR_W-1:0] r_haddr1;
    logic [ADDR_W-1:0] r_haddr2;
    logic [DATA_W-1:0] r_hwdata1;
    logic [DATA_W-1:0] r_hwdata2;
    logic              r_hwritereg;
    logic              r_hwritereg1;

    ahb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .MAP_BASE   (MAP_BASE),
        .SLAVE_SPAN (SLAVE_SPAN)
    ) u_decode (
        .i_haddr    (bus.Haddr),
        .o_tempselx (w_tempselx),
        .o_mapped   (w_mapped)
    );

    assign w_active  = bus.Hreadyin & htrans_active(bus.Htrans);
    assign w_err_req = w_active & ~w_mapped;

    // Address/data/direction pipeline, advancing only while the bus is ready.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_haddr1     <= '0;
            r_haddr2     <= '0;
            r_hwdata1    <= '0;
            r_hwdata2    <= '0;
            r_hwritereg  <= 1'b0;
            r_hwritereg1 <= 1'b0;
        end else if (bus.Hreadyin) begin
            r_haddr1     <= bus.Haddr;
            r_haddr2     <= r_haddr1;
            r_hwdata1    <= bus.Hwdata;
            r_hwdata2    <= r_hwdata1;
            r_hwritereg  <= bus.Hwrite;
            r_hwritereg1 <= r_hwritereg;
        end else begin
            r_haddr1     <= r_haddr1;
            r_haddr2     <= r_haddr2;
            r_hwdata1    <= r_hwdata1;
            r_hwdata2    <= r_hwdata2;
            r_hwritereg  <= r_hwritereg;
            r_hwritereg1 <= r_hwritereg1;
        end
    end

    // Error FSM state register.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ERR_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Error FSM next state and the response it drives back to the master.
    always_comb begin
        w_next      = r_state;
        w_hreadyout = 1'b1;
        w_hresp     = HRESP_OKAY;
        case (r_state)
            ERR_IDLE: begin
                w_hreadyout = bus.apb_ready;
                if (w_err_req) begin
                    w_next = ERR_1;
                end else begin
                    w_next = ERR_IDLE;
                end
            end
            ERR_1: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
                w_next      = ERR_2;
            end
            ERR_2: begin
                w_hreadyout = 1'b1;
                w_hresp     = HRESP_ERROR;
                if (w_err_req) begin
                    w_next = ERR_1;
                end else begin
                    w_next = ERR_IDLE;
                end
            end
            default: begin
                w_hreadyout = 1'b1;
                w_hresp     = HRESP_OKAY;
                w_next      = ERR_IDLE;
            end
        endcase
    end

    // The master must see a ready OKAY bus while reset is held, whatever apb_ready does.
    assign bus.Hreadyout  = Hresetn ? w_hreadyout : 1'b1;
    assign bus.Hresp      = Hresetn ? w_hresp : HRESP_OKAY;
    assign bus.valid      = w_active & w_mapped & (r_state != ERR_1);
    assign bus.tempselx   = w_tempselx;
    assign bus.Hrdata     = bus.Prdata;
    assign bus.Haddr1     = r_haddr1;
    assign bus.Haddr2     = r_haddr2;
    assign bus.Hwdata1    = r_hwdata1;
    assign bus.Hwdata2    = r_hwdata2;
    assign bus.Hwritereg  = r_hwritereg;
    assign bus.Hwritereg1 = r_hwritereg1;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed bench for ahb_slave_interface with a transaction-level reference model.
module tb_ahb_slave_interface;
    logic Hclk = 1'b0;
    logic Hresetn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ahb_slave_interface_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    ahb_slave_interface dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bif)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slave index by address arithmetic, histories of accepted phases.
    logic [31:0] aq[$];
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    int          m_phase = 0;

    function automatic int dec_idx(input logic [31:0] a);
        logic [63:0] off;
        if (a < 32'h8000_0000) return -1;
        off = {32'h0, a} - 64'h8000_0000;
        if ((off / 64'h0400_0000) > 64'd2) return -1;
        return int'(off / 64'h0400_0000);
    endfunction

    function automatic logic [31:0] hist(input logic [31:0] q[$], input int back);
        if (q.size() > back) return q[q.size() - 1 - back];
        return 32'h0;
    endfunction

    function automatic logic is_active();
        return bif.Hreadyin && (bif.Htrans == 2'b10 || bif.Htrans == 2'b11);
    endfunction

    always @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            aq.delete();
            wq.delete();
            rq.delete();
            m_phase <= 0;
        end else begin
            if (bif.Hreadyin) begin
                aq.push_back(bif.Haddr);
                wq.push_back(bif.Hwdata);
                rq.push_back({31'h0, bif.Hwrite});
                if (aq.size() > 2) begin
                    void'(aq.pop_front());
                    void'(wq.pop_front());
                    void'(rq.pop_front());
                end
            end
            if (m_phase == 1) m_phase <= 2;
            else if (is_active() && dec_idx(bif.Haddr) < 0) m_phase <= 1;
            else m_phase <= 0;
        end
    end

    always @(negedge Hclk) begin
        int          idx;
        logic [2:0]  e_sel;
        logic        e_rdy;
        idx   = dec_idx(bif.Haddr);
        e_sel = (idx >= 0) ? (3'b001 << idx) : 3'b000;
        e_rdy = !Hresetn ? 1'b1 : (m_phase == 1) ? 1'b0 : (m_phase == 2) ? 1'b1 : bif.apb_ready;
        chk("m_valid", bif.valid, is_active() && idx >= 0 && m_phase != 1);
        chk("m_tempselx", bif.tempselx, e_sel);
        chk("m_Haddr1", bif.Haddr1, hist(aq, 0));
        chk("m_Haddr2", bif.Haddr2, hist(aq, 1));
        chk("m_Hwdata1", bif.Hwdata1, hist(wq, 0));
        chk("m_Hwdata2", bif.Hwdata2, hist(wq, 1));
        chk("m_Hwritereg", bif.Hwritereg, hist(rq, 0));
        chk("m_Hwritereg1", bif.Hwritereg1, hist(rq, 1));
        chk("m_Hreadyout", bif.Hreadyout, e_rdy);
        chk("m_Hresp", bif.Hresp, (Hresetn && m_phase != 0) ? 2'b01 : 2'b00);
        chk("m_Hrdata", bif.Hrdata, bif.Prdata);
    end

    task automatic step();
        @(posedge Hclk);
        #2;
    endtask

    logic [31:0] tbl_addr[9];
    logic [2:0]  tbl_sel[9];

    initial begin
        bif.Hwrite = 1'b0; bif.Hreadyin = 1'b1; bif.Htrans = 2'b00;
        bif.Haddr = 32'h0; bif.Hwdata = 32'h0; bif.Prdata = 32'h0; bif.apb_ready = 1'b1;
        tbl_addr = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000, 32'h8BFF_FFFF,
                     32'h8C00_0000, 32'h8000_0004, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl_sel  = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000};
        #3;
        chk("rst_Hreadyout", bif.Hreadyout, 1'b1);
        chk("rst_Hresp", bif.Hresp, 2'b00);
        chk("rst_Haddr1", bif.Haddr1, 32'h0);
        step(); step();
        Hresetn = 1'b1;

        // Single mapped write
        step();
        bif.Haddr = 32'h8000_0001; bif.Htrans = 2'b10; bif.Hwrite = 1'b1;
        #1;
        chk("wr_valid", bif.valid, 1'b1);
        chk("wr_tempselx", bif.tempselx, 3'b001);
        step();
        bif.Htrans = 2'b00; bif.Haddr = 32'h8000_0004; bif.Hwdata = 32'hA3; bif.Hwrite = 1'b0;
        #1;
        chk("wr_Haddr1", bif.Haddr1, 32'h8000_0001);
        chk("wr_Hwritereg", bif.Hwritereg, 1'b1);
        chk("wr_Hresp", bif.Hresp, 2'b00);
        step();
        chk("wr_Hwdata1", bif.Hwdata1, 32'hA3);

        // Read to slave 2
        bif.Haddr = 32'h8800_00A2; bif.Htrans = 2'b10; bif.Hwrite = 1'b0; bif.Prdata = 32'h1234_5678;
        #1;
        chk("rd_tempselx", bif.tempselx, 3'b100);
        chk("rd_valid", bif.valid, 1'b1);
        chk("rd_Hrdata", bif.Hrdata, 32'h1234_5678);
        step();
        bif.Htrans = 2'b00;
        #1;
        chk("rd_Hwritereg", bif.Hwritereg, 1'b0);

        // Unmapped address: two-cycle ERROR
        step();
        bif.Haddr = 32'h9000_0000; bif.Htrans = 2'b10;
        #1;
        chk("um_valid", bif.valid, 1'b0);
        chk("um_tempselx", bif.tempselx, 3'b000);
        step();
        bif.Htrans = 2'b00;
        #1;
        chk("um_e1_Hreadyout", bif.Hreadyout, 1'b0);
        chk("um_e1_Hresp", bif.Hresp, 2'b01);
        step();
        chk("um_e2_Hreadyout", bif.Hreadyout, 1'b1);
        chk("um_e2_Hresp", bif.Hresp, 2'b01);
        step();
        chk("um_done_Hresp", bif.Hresp, 2'b00);

        // Stall with changing address
        bif.Haddr = 32'h8000_0010; bif.Htrans = 2'b10; bif.Hwdata = 32'h0;
        step();
        bif.Haddr = 32'h8000_0020; bif.Hwdata = 32'h5555_0001;
        step();
        bif.Hreadyin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bif.Haddr = 32'h8000_0030 + 32'(i * 4); bif.Hwdata = 32'h6666_0000 + 32'(i);
            #1;
            chk("st_valid", bif.valid, 1'b0);
            chk("st_Haddr1", bif.Haddr1, 32'h8000_0020);
            chk("st_Haddr2", bif.Haddr2, 32'h8000_0010);
            chk("st_Hwdata1", bif.Hwdata1, 32'h5555_0001);
            step();
        end

        // IDLE and BUSY on a mapped address
        bif.Hreadyin = 1'b1; bif.Htrans = 2'b00; bif.Haddr = 32'h8400_0000;
        #1;
        chk("idle_valid", bif.valid, 1'b0);
        chk("idle_tempselx", bif.tempselx, 3'b010);
        step();
        bif.Htrans = 2'b01; bif.Haddr = 32'h8400_0004;
        #1;
        chk("busy_valid", bif.valid, 1'b0);
        step();
        bif.Htrans = 2'b00;
        #1;
        chk("busy_Haddr1", bif.Haddr1, 32'h8400_0004);
        chk("busy_Haddr2", bif.Haddr2, 32'h8400_0000);
        chk("busy_Hresp", bif.Hresp, 2'b00);

        // Address-map boundaries, back-to-back
        for (int i = 0; i < 9; i++) begin
            step();
            bif.Haddr = tbl_addr[i]; bif.Htrans = 2'b10; bif.Hwrite = i[0];
            #1;
            chk("map_tempselx", bif.tempselx, tbl_sel[i]);
        end
        step();
        bif.Htrans = 2'b00;
        step(); step(); step();

        // Reset while in ERR1
        bif.Haddr = 32'h7000_0000; bif.Htrans = 2'b10;
        step();
        bif.Htrans = 2'b00; bif.apb_ready = 1'b0;
        #1;
        chk("re_e1_Hreadyout", bif.Hreadyout, 1'b0);
        chk("re_e1_Hresp", bif.Hresp, 2'b01);
        Hresetn = 1'b0;
        #1;
        chk("re_Hreadyout", bif.Hreadyout, 1'b1);
        chk("re_Hresp", bif.Hresp, 2'b00);
        chk("re_Haddr1", bif.Haddr1, 32'h0);
        step(); step();
        Hresetn = 1'b1;
        step();
        chk("re_after_Hresp", bif.Hresp, 2'b00);
        chk("re_after_Hreadyout", bif.Hreadyout, 1'b0);
        bif.apb_ready = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
